// File: rtl/qgate_pipe.sv
// Two-stage pipelined single-qubit gate engine on complex fixed-point amplitudes.
// Stage 1 selects/adds operands at WIDTH+1 bits; stage 2 scales by 1/sqrt2, rounds and saturates.
module qgate_pipe #(
    parameter int WIDTH       = 32,
    parameter int FRAC        = 16,
    parameter int K_INV_SQRT2 = 46341,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       gate_type,
    input  logic [WIDTH-1:0] alpha_re_in,
    input  logic [WIDTH-1:0] alpha_im_in,
    input  logic [WIDTH-1:0] beta_re_in,
    input  logic [WIDTH-1:0] beta_im_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alpha_re_out,
    output logic [WIDTH-1:0] alpha_im_out,
    output logic [WIDTH-1:0] beta_re_out,
    output logic [WIDTH-1:0] beta_im_out,
    output logic             out_sat,
    output logic             out_err,
    output logic             sat_sticky,
    output logic [CNT_W-1:0] op_count
);

    localparam int EW = WIDTH + 1;
    localparam int PW = WIDTH + FRAC + 3;

    localparam logic [FRAC:0] K = K_INV_SQRT2[FRAC:0];
    localparam logic signed [PW-1:0] K_EXT = {{(PW-FRAC-1){1'b0}}, K};
    localparam logic signed [PW-1:0] RND   = {{(PW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
    localparam logic signed [PW-1:0] MAXV  = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] MINV  = {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef logic signed [EW-1:0] ext_t;
    typedef enum logic [2:0] {
        G_I = 3'b000, G_H = 3'b001, G_X = 3'b010, G_Z = 3'b011,
        G_Y = 3'b100, G_S = 3'b101, G_T = 3'b110, G_RSV = 3'b111
    } gate_t;

    function automatic ext_t sx(input logic [WIDTH-1:0] v);
        return {v[WIDTH-1], v};
    endfunction

    // Returns {saturated, value}; scaled terms get x*K/2^FRAC with round-half-up.
    function automatic logic [WIDTH:0] finish_term(input ext_t v, input logic scale);
        logic signed [PW-1:0] x;
        logic signed [PW-1:0] r;
        x = {{(PW-EW){v[EW-1]}}, v};
        r = scale ? ((x * K_EXT + RND) >>> FRAC) : x;
        if (r > MAXV)
            return {1'b1, MAXV[WIDTH-1:0]};
        else if (r < MINV)
            return {1'b1, MINV[WIDTH-1:0]};
        else
            return {1'b0, r[WIDTH-1:0]};
    endfunction

    gate_t gate_e;
    logic  accept;
    logic  rdy_q;

    ext_t  n_ar, n_ai, n_br, n_bi;
    logic  n_sa, n_sb, n_err;

    logic  s1_valid;
    ext_t  s1_ar, s1_ai, s1_br, s1_bi;
    logic  s1_sa, s1_sb, s1_err;

    logic [WIDTH:0] f_ar, f_ai, f_br, f_bi;

    assign gate_e   = gate_t'(gate_type);
    assign in_ready = rdy_q & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
        n_ar  = sx(alpha_re_in);
        n_ai  = sx(alpha_im_in);
        n_br  = sx(beta_re_in);
        n_bi  = sx(beta_im_in);
        n_sa  = 1'b0;
        n_sb  = 1'b0;
        n_err = 1'b0;
        case (gate_e)
            G_I: ;
            G_H: begin
                n_ar = sx(alpha_re_in) + sx(beta_re_in);
                n_ai = sx(alpha_im_in) + sx(beta_im_in);
                n_br = sx(alpha_re_in) - sx(beta_re_in);
                n_bi = sx(alpha_im_in) - sx(beta_im_in);
                n_sa = 1'b1;
                n_sb = 1'b1;
            end
            G_X: begin
                n_ar = sx(beta_re_in);
                n_ai = sx(beta_im_in);
                n_br = sx(alpha_re_in);
                n_bi = sx(alpha_im_in);
            end
            G_Z: begin
                n_br = -sx(beta_re_in);
                n_bi = -sx(beta_im_in);
            end
            G_Y: begin
                n_ar = sx(beta_im_in);
                n_ai = -sx(beta_re_in);
                n_br = -sx(alpha_im_in);
                n_bi = sx(alpha_re_in);
            end
            G_S: begin
                n_br = -sx(beta_im_in);
                n_bi = sx(beta_re_in);
            end
            G_T: begin
                n_br = sx(beta_re_in) - sx(beta_im_in);
                n_bi = sx(beta_re_in) + sx(beta_im_in);
                n_sb = 1'b1;
            end
            G_RSV: n_err = 1'b1;
        endcase
    end

    assign f_ar = finish_term(s1_ar, s1_sa);
    assign f_ai = finish_term(s1_ai, s1_sa);
    assign f_br = finish_term(s1_br, s1_sb);
    assign f_bi = finish_term(s1_bi, s1_sb);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_q        <= 1'b0;
            s1_valid     <= 1'b0;
            s1_ar        <= '0;
            s1_ai        <= '0;
            s1_br        <= '0;
            s1_bi        <= '0;
            s1_sa        <= 1'b0;
            s1_sb        <= 1'b0;
            s1_err       <= 1'b0;
            out_valid    <= 1'b0;
            alpha_re_out <= '0;
            alpha_im_out <= '0;
            beta_re_out  <= '0;
            beta_im_out  <= '0;
            out_sat      <= 1'b0;
            out_err      <= 1'b0;
            sat_sticky   <= 1'b0;
            op_count     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            rdy_q <= 1'b1;
            if (accept)
                op_count <= op_count + CNT_W'(1);
            if (out_valid && out_ready && out_sat)
                sat_sticky <= 1'b1;
            // Single global enable: both stages move together or hold together.
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_ar  <= n_ar;
                    s1_ai  <= n_ai;
                    s1_br  <= n_br;
                    s1_bi  <= n_bi;
                    s1_sa  <= n_sa;
                    s1_sb  <= n_sb;
                    s1_err <= n_err;
                end
                out_valid <= s1_valid;
                if (s1_valid) begin
                    alpha_re_out <= f_ar[WIDTH-1:0];
                    alpha_im_out <= f_ai[WIDTH-1:0];
                    beta_re_out  <= f_br[WIDTH-1:0];
                    beta_im_out  <= f_bi[WIDTH-1:0];
                    out_sat      <= f_ar[WIDTH] | f_ai[WIDTH] | f_br[WIDTH] | f_bi[WIDTH];
                    out_err      <= s1_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_qgate_pipe.sv
// Self-checking bench for qgate_pipe: vector table driven through a scoreboard,
// plus hand-written backpressure and mid-operation reset sequences.
module tb_qgate_pipe;

    localparam int WIDTH = 32;
    localparam int FRAC  = 16;
    localparam int CNT_W = 4;   // small counter so the wrap is reached quickly

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready, out_valid, out_ready;
    logic [2:0]       gate_type;
    logic [WIDTH-1:0] alpha_re_in, alpha_im_in, beta_re_in, beta_im_in;
    logic [WIDTH-1:0] alpha_re_out, alpha_im_out, beta_re_out, beta_im_out;
    logic             out_sat, out_err, sat_sticky;
    logic [CNT_W-1:0] op_count;

    qgate_pipe #(.WIDTH(WIDTH), .FRAC(FRAC), .K_INV_SQRT2(46341), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .gate_type(gate_type),
        .alpha_re_in(alpha_re_in), .alpha_im_in(alpha_im_in),
        .beta_re_in(beta_re_in), .beta_im_in(beta_im_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .alpha_re_out(alpha_re_out), .alpha_im_out(alpha_im_out),
        .beta_re_out(beta_re_out), .beta_im_out(beta_im_out),
        .out_sat(out_sat), .out_err(out_err), .sat_sticky(sat_sticky), .op_count(op_count)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] GI = 3'b000, GH = 3'b001, GX = 3'b010, GZ = 3'b011;
    localparam logic [2:0] GY = 3'b100, GS = 3'b101, GT = 3'b110, GR = 3'b111;

    typedef struct {
        int               idx;
        logic [2:0]       g;
        logic [WIDTH-1:0] ar, ai, br, bi;
        logic [WIDTH-1:0] ear, eai, ebr, ebi;
        logic             esat, eerr;
    } vec_t;

    typedef struct {
        vec_t v;
        int   cyc;
        logic chk_lat;
    } sb_t;

    vec_t vt[15];
    vec_t bp[3];
    vec_t fresh;
    sb_t  sb[$];
    sb_t  mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   n_acc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic vec_t mk(input int idx, input logic [2:0] g,
                                input logic [WIDTH-1:0] ar, ai, br, bi,
                                input logic [WIDTH-1:0] ear, eai, ebr, ebi,
                                input logic esat, eerr);
        vec_t v;
        v.idx = idx; v.g = g;
        v.ar = ar; v.ai = ai; v.br = br; v.bi = bi;
        v.ear = ear; v.eai = eai; v.ebr = ebr; v.ebi = ebi;
        v.esat = esat; v.eerr = eerr;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s", name, what);
    endtask

    task automatic drive(input vec_t v);
        gate_type   = v.g;
        alpha_re_in = v.ar;
        alpha_im_in = v.ai;
        beta_re_in  = v.br;
        beta_im_in  = v.bi;
        in_valid    = 1'b1;
    endtask

    // Waits for in_ready at a negedge, records the expected result, returns just after the accepting edge.
    task automatic wait_accept(input vec_t v, input logic chk_lat);
        sb_t e;
        int  k = 0;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            k++;
            @(negedge clk);
        end
        if (!in_ready) begin
            fail_now($sformatf("accept_timeout_v%0d", v.idx), "in_ready never rose");
        end else begin
            e.v = v; e.cyc = cyc; e.chk_lat = chk_lat;
            sb.push_back(e);
            n_acc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input vec_t v, input logic chk_lat);
        drive(v);
        wait_accept(v, chk_lat);
    endtask

    task automatic drain();
        int k = 0;
        in_valid = 1'b0;
        while (sb.size() != 0 && k < 30) begin
            @(posedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        if (sb.size() != 0)
            fail_now("drain_timeout", $sformatf("%0d results never appeared", sb.size()));
    endtask

    // Scoreboard consumer: one pop per output handshake, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                fail_now("unexpected_output", $sformatf("got alpha_re 0x%0h, expected no result", alpha_re_out));
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("v%0d_alpha_re", mon_e.v.idx), alpha_re_out, mon_e.v.ear);
                check($sformatf("v%0d_alpha_im", mon_e.v.idx), alpha_im_out, mon_e.v.eai);
                check($sformatf("v%0d_beta_re", mon_e.v.idx), beta_re_out, mon_e.v.ebr);
                check($sformatf("v%0d_beta_im", mon_e.v.idx), beta_im_out, mon_e.v.ebi);
                check($sformatf("v%0d_out_sat", mon_e.v.idx), out_sat, mon_e.v.esat);
                check($sformatf("v%0d_out_err", mon_e.v.idx), out_err, mon_e.v.eerr);
                if (mon_e.chk_lat)
                    check($sformatf("v%0d_latency", mon_e.v.idx), 64'(cyc - mon_e.cyc), 64'd2);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = mk(0,  GH, 32'h0001_0000, 0, 0, 0,  32'h0000_B505, 0, 32'h0000_B505, 0, 0, 0);
        vt[1]  = mk(1,  GI, 32'h0001_0000, 0, 32'h8000, 0,  32'h0001_0000, 0, 32'h8000, 0, 0, 0);
        vt[2]  = mk(2,  GX, 32'h0001_0000, 0, 32'h8000, 0,  32'h8000, 0, 32'h0001_0000, 0, 0, 0);
        vt[3]  = mk(3,  GY, 32'h0001_0000, 0, 32'h8000, 0,  0, 32'hFFFF_8000, 0, 32'h0001_0000, 0, 0);
        vt[4]  = mk(4,  GS, 32'h0001_0000, 0, 32'h8000, 0,  32'h0001_0000, 0, 0, 32'h8000, 0, 0);
        vt[5]  = mk(5,  GT, 32'h0001_0000, 0, 32'h8000, 0,  32'h0001_0000, 0, 32'h5A83, 32'h5A83, 0, 0);
        vt[6]  = mk(6,  GZ, 32'h0001_0000, 0, 32'h8000, 32'h1234,
                        32'h0001_0000, 0, 32'hFFFF_8000, 32'hFFFF_EDCC, 0, 0);
        vt[7]  = mk(7,  GH, 32'h0001_0000, 0, 0, 32'h0001_0000,
                        32'hB505, 32'hB505, 32'hB505, 32'hFFFF_4AFB, 0, 0);
        vt[8]  = mk(8,  GT, 1, 2, 32'h0001_0000, 32'h0001_0000,  1, 2, 0, 32'h0001_6A0A, 0, 0);
        vt[9]  = mk(9,  GZ, 0, 0, 32'h8000_0000, 0,  0, 0, 32'h7FFF_FFFF, 0, 1, 0);
        vt[10] = mk(10, GH, 32'h7FFF_FFFF, 0, 32'h7FFF_FFFF, 0,  32'h7FFF_FFFF, 0, 0, 0, 1, 0);
        vt[11] = mk(11, GR, 32'h1234_5678, 32'hDEAD_BEEF, 32'h8000_0000, 32'h7FFF_FFFF,
                        32'h1234_5678, 32'hDEAD_BEEF, 32'h8000_0000, 32'h7FFF_FFFF, 0, 1);
        vt[12] = mk(12, GY, 0, 0, 32'h8000_0000, 5,  5, 32'h7FFF_FFFF, 0, 0, 1, 0);
        vt[13] = mk(13, GH, 0, 0, 32'h8000, 0,  32'h5A83, 0, 32'hFFFF_A57E, 0, 0, 0);
        vt[14] = mk(14, GH, 32'h8000_0000, 0, 32'h8000_0000, 0,  32'h8000_0000, 0, 0, 0, 1, 0);

        bp[0] = mk(100, GI, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444,
                       32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 0, 0);
        bp[1] = mk(101, GX, 1, 2, 3, 4,  3, 4, 1, 2, 0, 0);
        bp[2] = mk(102, GZ, 5, 6, 7, 8,  5, 6, 32'hFFFF_FFF9, 32'hFFFF_FFF8, 0, 0);

        fresh = mk(200, GH, 32'h0001_0000, 0, 0, 0,  32'h0000_B505, 0, 32'h0000_B505, 0, 0, 0);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; gate_type = '0;
        alpha_re_in = '0; alpha_im_in = '0; beta_re_in = '0; beta_im_in = '0;

        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_op_count", op_count, 0);
        check("rst_sat_sticky", sat_sticky, 0);
        check("rst_alpha_re_out", alpha_re_out, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_after_rst", in_ready, 1);

        // Single H op on |0>.
        send(vt[0], 1);
        drain();
        check("op_count_after_h", op_count, 64'(n_acc % (1 << CNT_W)));

        // Back-to-back I, X, Y, S, T, then the rest of the table; sticky only after a saturating op.
        for (int i = 1; i <= 8; i++) send(vt[i], 1);
        drain();
        check("op_count_after_stream", op_count, 64'(n_acc % (1 << CNT_W)));
        check("sat_sticky_before_sat", sat_sticky, 0);
        for (int i = 9; i < 15; i++) send(vt[i], 1);
        drain();
        check("sat_sticky_after_sat", sat_sticky, 1);
        check("op_count_after_table", op_count, 64'(n_acc % (1 << CNT_W)));

        // Backpressure: consumer stalls for 4 cycles while 3 ops stream in.
        out_ready = 1'b0;
        send(bp[0], 0);
        check("op_count_wrap", op_count, 64'(n_acc % (1 << CNT_W)));
        send(bp[1], 0);
        drive(bp[2]);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("stall%0d_in_ready", i), in_ready, 0);
            check($sformatf("stall%0d_out_valid", i), out_valid, 1);
            check($sformatf("stall%0d_alpha_re_hold", i), alpha_re_out, bp[0].ear);
            check($sformatf("stall%0d_beta_im_hold", i), beta_im_out, bp[0].ebi);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_accept(bp[2], 0);
        drain();
        check("op_count_after_bp", op_count, 64'(n_acc % (1 << CNT_W)));

        // Reset with two ops in flight.
        send(vt[1], 1);
        send(vt[2], 1);
        in_valid = 1'b0;
        check("inflight_out_valid", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_sat_sticky", sat_sticky, 0);
        check("midrst_op_count", op_count, 0);
        sb.delete();
        n_acc = 0;
        #4;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_no_stale", out_valid, 0);

        send(fresh, 1);
        drain();
        check("op_count_after_fresh", op_count, 64'(n_acc % (1 << CNT_W)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/qgate_pipe.md
Name: qgate_pipe

Overview:
- Pipelined, parametrised single-qubit gate engine; next generation of the combinational Q16.16 gate unit.
- Operates on complex amplitudes (re/im for α and β), so Y, S and T gates are exact.
- Uses a valid/ready stream with fixed latency, round-to-nearest and saturating arithmetic.
- Sits between the gate controller (issues gate ops) and the state register file (stores amplitudes).

Parameters:
- WIDTH, 32, signed amplitude word width (two's complement fixed point).
- FRAC, 16, fractional bits (default format Q16.16; 1.0 = 2^FRAC).
- K_INV_SQRT2, 46341 (0xB505), round(2^FRAC/√2), unsigned, FRAC+1 bits max.
- CNT_W, 16, width of accepted-operation counter.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input op valid.
- in_ready  out  1  engine can accept op this cycle.
- gate_type  in  3  000 I, 001 H, 010 X, 011 Z, 100 Y, 101 S, 110 T, 111 reserved.
- alpha_re_in, alpha_im_in, beta_re_in, beta_im_in  in  WIDTH each  input amplitudes, signed.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- alpha_re_out, alpha_im_out, beta_re_out, beta_im_out  out  WIDTH each  result amplitudes.
- out_sat  out  1  this result saturated in at least one component.
- out_err  out  1  this result came from gate_type 111 (passed as identity).
- sat_sticky  out  1  set on any saturated result leaving the engine; cleared only by rst.
- op_count  out  CNT_W  number of accepted input ops, wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, immediate) clears all pipeline valids, all outputs, out_sat, out_err, sat_sticky and op_count to 0. in_ready is 1 from the first clk edge after rst deasserts.
- Any ops in flight when rst asserts mid-operation are discarded. No partial results appear afterwards.
- Two-stage pipeline; latency exactly 2 cycles from accept (in_valid & in_ready) to out_valid, for every gate type.
- Throughput is 1 op/cycle.
- Global stall: in_ready = ~out_valid | out_ready. Both stages advance only when in_ready = 1.
- While out_valid = 1 and out_ready = 0, all outputs hold stable. No op is lost or duplicated.
- Bubbles propagate. out_valid falls when an empty stage reaches the output.
- Stage 1 (operand select/add, WIDTH+1-bit signed intermediates):
  - H: sα = α + β, sβ = α − β, per re/im.
  - T: tr = β_re − β_im, ti = β_re + β_im.
  - Others: plain select/negate, held WIDTH+1 wide.
- Stage 2 (scale, round, saturate):
  - H and T terms are multiplied by K_INV_SQRT2, then 2^(FRAC−1) is added, then the result is arithmetic-shifted right by FRAC. This is round-half-up.
  - All results are then saturated to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- Gate functions:
  - I: unchanged.
  - X: α' = β, β' = α.
  - Z: β' = −β.
  - Y: α' = −iβ, i.e. (β_im, −β_re); β' = iα, i.e. (−α_im, α_re).
  - S: β' = iβ, i.e. (−β_im, β_re).
  - T: β' = ((β_re−β_im)/√2, (β_re+β_im)/√2).
  - 111: identity with out_err = 1.
- Negation of −2^(WIDTH−1) saturates to 2^(WIDTH−1)−1 and sets out_sat.
- out_sat and out_err travel with their op through the pipeline.
- sat_sticky sets on the cycle out_valid & out_ready & out_sat occurs.
- op_count increments on each accept. It wraps from 2^CNT_W−1 to 0.

Test Plan:
- H on |0⟩: α_re = 0x00010000, others 0 → 2 cycles later α_re = β_re = 0x0000B505, α_im = β_im = 0, out_sat = 0, op_count = 1.
- Back-to-back I, X, Y, S, T ops with α_re = 0x00010000, β_re = 0x00008000, in_valid held high. Required results in order:
  - I: α = (0x10000, 0), β = (0x8000, 0).
  - X: α = (0x8000, 0), β = (0x10000, 0).
  - Y: α = (0, −0x8000), β = (0, 0x10000).
  - S: β = (0, 0x8000).
  - T: β = (0x5A83, 0x5A83).
  - One result per cycle; op_count = 5.
- Backpressure: hold out_ready = 0 for 4 cycles while streaming 3 ops → in_ready drops after the pipeline fills, outputs stay frozen, all 3 results emerge in order once out_ready = 1.
- Saturation: Z with β_re = 0x80000000 → β_re_out = 0x7FFFFFFF, out_sat = 1, sat_sticky = 1 after handshake. H with α_re = β_re = 0x7FFFFFFF → α_re_out = 0x7FFFFFFF (saturated), β_re_out = 0.
- Reserved gate 111 with arbitrary inputs → outputs equal inputs, out_err = 1, out_sat = 0.
- Reset mid-operation: assert rst asynchronously with 2 ops in flight → out_valid = 0, sat_sticky = 0, op_count = 0 immediately. No stale result appears after release. A fresh H op yields the correct result after 2 cycles.
